// File: rtl/constants_pkg.sv
// Shared opcode/ALU-op encodings and the sequencer state type used by the
// alu_registers datapath and its instruction sequencer.
package constants_pkg;

  typedef enum logic [1:0] {
    REG_READ  = 2'b00,
    REG_WRITE = 2'b01,
    ADD       = 2'b10,
    SUB       = 2'b11
  } ALUOp;

  localparam logic [1:0] OPC_READ  = 2'b00;
  localparam logic [1:0] OPC_WRITE = 2'b01;
  localparam logic [1:0] OPC_ADD   = 2'b10;
  localparam logic [1:0] OPC_SUB   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT,
    RESP
  } SeqState;

  function automatic ALUOp opc_to_aluop(input logic [1:0] opc);
    ALUOp r;
    case (opc)
      OPC_WRITE: r = REG_WRITE;
      OPC_ADD:   r = ADD;
      OPC_SUB:   r = SUB;
      default:   r = REG_READ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_instr_fields.sv
// Splits a packed instruction word into opcode, register addresses and
// immediate; rB shares the low bits of the immediate field.
module alu_instr_fields
  import constants_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 3,
  parameter int unsigned DATA_BITS = 8,
  localparam int unsigned INSTR_BITS = 2 + 2*ADDR_BITS + DATA_BITS
) (
  input  logic [INSTR_BITS-1:0] instr,
  output logic [1:0]            opcode,
  output logic [ADDR_BITS-1:0]  rr,
  output logic [ADDR_BITS-1:0]  ra,
  output logic [ADDR_BITS-1:0]  rb,
  output logic [DATA_BITS-1:0]  imm
);

  always_comb begin
    opcode = instr[INSTR_BITS-1 -: 2];
    rr     = instr[DATA_BITS+2*ADDR_BITS-1 -: ADDR_BITS];
    ra     = instr[DATA_BITS+ADDR_BITS-1 -: ADDR_BITS];
    imm    = instr[DATA_BITS-1:0];
    rb     = instr[ADDR_BITS-1:0];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer for alu_registers: issues each op for exactly one
// cycle, waits for the datapath to settle, and returns READ data.
module alu_sequencer
  import constants_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 3,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned INSTR_BITS   = 2 + 2*ADDR_BITS + DATA_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [INSTR_BITS-1:0] instr,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [DATA_BITS-1:0]  result,
  output logic                  done,
  output ALUOp                  op,
  output logic [ADDR_BITS-1:0]  addr_a,
  output logic [ADDR_BITS-1:0]  addr_b,
  output logic [ADDR_BITS-1:0]  addr_r,
  output logic [DATA_BITS-1:0]  data_in,
  input  logic [DATA_BITS-1:0]  data_out
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  SeqState              state, state_d;
  logic [3:0]           cnt, cnt_d;
  logic                 load, capture;

  logic [1:0]           dec_opc;
  logic [ADDR_BITS-1:0] dec_rr, dec_ra, dec_rb;
  logic [DATA_BITS-1:0] dec_imm;

  logic [1:0]           lat_opc;
  logic [ADDR_BITS-1:0] lat_rr, lat_ra, lat_rb;
  logic [DATA_BITS-1:0] lat_imm;

  logic [1:0]           f_opc;
  logic [ADDR_BITS-1:0] f_rr, f_ra, f_rb;
  logic [DATA_BITS-1:0] f_imm;

  ALUOp                 op_d;
  logic [ADDR_BITS-1:0] addr_a_d, addr_b_d, addr_r_d;
  logic [DATA_BITS-1:0] data_in_d;
  logic                 ready_d, rvalid_d, done_d;

  alu_instr_fields #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_fields (
    .instr  (instr),
    .opcode (dec_opc),
    .rr     (dec_rr),
    .ra     (dec_ra),
    .rb     (dec_rb),
    .imm    (dec_imm)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          state_d = DRIVE;
          load    = 1'b1;
        end
      end
      DRIVE: begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: begin
        if (cnt == '0) begin
          if (lat_opc == OPC_READ) begin
            state_d = RESP;
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state and registered, so on an
  // accepting edge the freshly decoded fields feed the DRIVE-cycle flops.
  always_comb begin
    f_opc = load ? dec_opc : lat_opc;
    f_rr  = load ? dec_rr  : lat_rr;
    f_ra  = load ? dec_ra  : lat_ra;
    f_rb  = load ? dec_rb  : lat_rb;
    f_imm = load ? dec_imm : lat_imm;

    op_d      = REG_READ;
    addr_a_d  = '0;
    addr_b_d  = '0;
    addr_r_d  = '0;
    data_in_d = '0;
    ready_d   = 1'b0;
    rvalid_d  = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      IDLE: ready_d = 1'b1;
      DRIVE: begin
        op_d     = opc_to_aluop(f_opc);
        addr_a_d = f_ra;
        case (f_opc)
          OPC_WRITE: data_in_d = f_imm;
          OPC_ADD, OPC_SUB: begin
            addr_b_d = f_rb;
            addr_r_d = f_rr;
          end
          default: ;
        endcase
      end
      WAIT: begin
        addr_a_d = (f_opc == OPC_READ) ? f_ra : f_rr;
        done_d   = (cnt_d == '0) && (f_opc != OPC_READ);
      end
      RESP: rvalid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_opc      <= OPC_READ;
      lat_rr       <= '0;
      lat_ra       <= '0;
      lat_rb       <= '0;
      lat_imm      <= '0;
      result       <= '0;
      op           <= REG_READ;
      addr_a       <= '0;
      addr_b       <= '0;
      addr_r       <= '0;
      data_in      <= '0;
      instr_ready  <= 1'b1;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load) begin
        lat_opc <= dec_opc;
        lat_rr  <= dec_rr;
        lat_ra  <= dec_ra;
        lat_rb  <= dec_rb;
        lat_imm <= dec_imm;
      end
      if (capture) result <= data_out;
      op           <= op_d;
      addr_a       <= addr_a_d;
      addr_b       <= addr_b_d;
      addr_r       <= addr_r_d;
      data_in      <= data_in_d;
      instr_ready  <= ready_d;
      result_valid <= rvalid_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural register file attached and a
// register-level reference model of expected contents and timing.
module tb_alu_sequencer;
  import constants_pkg::*;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [15:0] instr;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] result;
  logic       done;
  ALUOp       op;
  logic [2:0] addr_a, addr_b, addr_r;
  logic [7:0] data_in;
  logic [7:0] data_out;

  alu_sequencer #(
    .ADDR_BITS     (3),
    .DATA_BITS     (8),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .done         (done),
    .op           (op),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .addr_r       (addr_r),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  // Register file environment: executes whatever op is presented on every edge.
  logic       env_clr;
  logic [7:0] rf [8];
  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else begin
      case (op)
        REG_WRITE: rf[addr_a] <= data_in;
        ADD:       rf[addr_r] <= rf[addr_a] + rf[addr_b];
        SUB:       rf[addr_r] <= rf[addr_a] - rf[addr_b];
        default: ;
      endcase
    end
  end
  assign data_out = rf[addr_a];

  int cyc = 0, acc_cnt = 0, mut_cnt = 0, done_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && instr_valid && instr_ready) acc_cnt <= acc_cnt + 1;
  end
  always @(negedge clk) begin
    if (op !== REG_READ) mut_cnt <= mut_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  logic [7:0] mref [8];
  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("ready_timeout", 32'(instr_ready), 32'd1);
  endtask

  function automatic ALUOp exp_op(input logic [1:0] opc);
    case (opc)
      2'd1:    return REG_WRITE;
      2'd2:    return ADD;
      2'd3:    return SUB;
      default: return REG_READ;
    endcase
  endfunction

  task automatic model_apply(input logic [1:0] opc, input logic [2:0] rr,
                             input logic [2:0] ra, input logic [7:0] lo);
    logic [2:0] rb;
    rb = lo[2:0];
    case (opc)
      2'd1: mref[ra] = lo;
      2'd2: mref[rr] = mref[ra] + mref[rb];
      2'd3: mref[rr] = mref[ra] - mref[rb];
      default: ;
    endcase
  endtask

  // One full instruction with cycle-by-cycle checks against the timing rules.
  task automatic run_instr(input logic [1:0] opc, input logic [2:0] rr,
                           input logic [2:0] ra, input logic [7:0] lo, input int stall);
    int m0, d0;
    logic [7:0] exp_res;
    logic [2:0] rb;
    logic is_rd, is_ar;
    rb    = lo[2:0];
    is_rd = (opc == 2'd0);
    is_ar = (opc == 2'd2) || (opc == 2'd3);
    wait_ready();
    m0 = mut_cnt;
    d0 = done_cnt;
    instr = {opc, rr, ra, lo};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    exp_res = mref[ra];
    model_apply(opc, rr, ra, lo);
    @(negedge clk);
    check("drive_op", 32'(op), 32'(exp_op(opc)));
    check("drive_addr_a", 32'(addr_a), 32'(ra));
    check("drive_addr_b", 32'(addr_b), is_ar ? 32'(rb) : 32'd0);
    check("drive_addr_r", 32'(addr_r), is_ar ? 32'(rr) : 32'd0);
    check("drive_data_in", 32'(data_in), (opc == 2'd1) ? 32'(lo) : 32'd0);
    check("drive_ready", 32'(instr_ready), 32'd0);
    for (int k = 1; k <= S; k++) begin
      @(negedge clk);
      check("wait_op", 32'(op), 32'(REG_READ));
      check("wait_addr_a", 32'(addr_a), is_rd ? 32'(ra) : 32'(rr));
      check("wait_done", 32'(done), (k == S && !is_rd) ? 32'd1 : 32'd0);
      check("wait_ready", 32'(instr_ready), 32'd0);
    end
    @(negedge clk);
    if (is_rd) begin
      check("resp_valid", 32'(result_valid), 32'd1);
      check("resp_result", 32'(result), 32'(exp_res));
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("stall_valid", 32'(result_valid), 32'd1);
        check("stall_result", 32'(result), 32'(exp_res));
        check("stall_ready", 32'(instr_ready), 32'd0);
      end
      result_ready = 1'b1;
      @(posedge clk);
      #1 result_ready = 1'b0;
      @(negedge clk);
      check("post_resp_valid", 32'(result_valid), 32'd0);
      check("post_resp_idle", 32'(instr_ready), 32'd1);
    end else begin
      check("retire_ready", 32'(instr_ready), 32'd1);
      check("retire_done_low", 32'(done), 32'd0);
    end
    check("mutating_cycles", 32'(mut_cnt - m0), is_rd ? 32'd0 : 32'd1);
    check("done_pulses", 32'(done_cnt - d0), is_rd ? 32'd0 : 32'd1);
  endtask

  initial begin
    int d0, a0;
    int t_acc [4];
    logic [15:0] b2b [4];
    reset = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    result_ready = 1'b0;
    env_clr = 1'b1;
    for (int i = 0; i < 8; i++) mref[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_rvalid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_op", 32'(op), 32'(REG_READ));
    check("rst_addrs", 32'({addr_a, addr_b, addr_r, data_in}), 32'd0);
    reset = 1'b1;
    env_clr = 1'b0;

    // WRITE then READ
    run_instr(2'd1, 3'd0, 3'd3, 8'h5A, 0);
    run_instr(2'd0, 3'd0, 3'd3, 8'h00, 0);
    // ADD r2 = r3 + r1
    run_instr(2'd1, 3'd0, 3'd1, 8'h10, 0);
    run_instr(2'd1, 3'd0, 3'd3, 8'h5A, 0);
    run_instr(2'd2, 3'd2, 3'd3, 8'h01, 0);
    run_instr(2'd0, 3'd0, 3'd2, 8'h00, 1);
    check("add_result_6a", 32'(mref[2]), 32'h6A);
    // SUB wrap-around, then single ADD with rR == rA
    run_instr(2'd1, 3'd0, 3'd4, 8'h00, 0);
    run_instr(2'd1, 3'd0, 3'd5, 8'h01, 0);
    run_instr(2'd3, 3'd6, 3'd4, 8'h05, 0);
    run_instr(2'd0, 3'd0, 3'd6, 8'h00, 0);
    run_instr(2'd2, 3'd4, 3'd4, 8'h05, 0);
    run_instr(2'd0, 3'd0, 3'd4, 8'h00, 0);
    check("no_accumulate_r4", 32'(rf[4]), 32'h01);
    // READ with consumer stalling
    run_instr(2'd0, 3'd0, 3'd1, 8'h00, 5);

    // Reset during WAIT of an ADD r7 = r3 + r1
    wait_ready();
    d0 = done_cnt;
    instr = {2'd2, 3'd7, 3'd3, 8'h01};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    model_apply(2'd2, 3'd7, 3'd3, 8'h01);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_rvalid", 32'(result_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_op", 32'(op), 32'(REG_READ));
    check("abort_addrs", 32'({addr_a, addr_b, addr_r, data_in}), 32'd0);
    repeat (4) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_instr(2'd0, 3'd0, 3'd7, 8'h00, 0);

    // Back-to-back with instr_valid held high
    b2b[0] = {2'd1, 3'd0, 3'd0, 8'h33};
    b2b[1] = {2'd1, 3'd0, 3'd1, 8'h44};
    b2b[2] = {2'd2, 3'd2, 3'd0, 8'h01};
    b2b[3] = {2'd3, 3'd3, 3'd2, 8'h00};
    a0 = acc_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      instr = b2b[i];
      instr_valid = 1'b1;
      t_acc[i] = cyc;
      @(posedge clk);
      #1;
      model_apply(b2b[i][15:14], b2b[i][13:11], b2b[i][10:8], b2b[i][7:0]);
      if (i < 3) instr = b2b[i+1];
    end
    instr_valid = 1'b0;
    for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(t_acc[i] - t_acc[i-1]), 32'(S + 2));
    wait_ready();
    check("b2b_accepted", 32'(acc_cnt - a0), 32'd4);
    check("b2b_done", 32'(done_cnt - d0), 32'd4);
    run_instr(2'd0, 3'd0, 3'd2, 8'h00, 0);
    run_instr(2'd0, 3'd0, 3'd3, 8'h00, 0);
    check("b2b_r3", 32'(mref[3]), 32'h44);

    // Randomized instruction mix
    for (int i = 0; i < 40; i++) begin
      run_instr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3));
    end
    for (int r = 0; r < 8; r++) check("final_rf", 32'(rf[r]), 32'(mref[r]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
